// File: rtl/io_trace_capture.sv
// I/O-bus write snooper: qualifying io_we cycles are recorded as {addr, data, ts} in a FIFO
// drained through a registered read port. Define IO_TRACE_TIMESTAMP_EN to keep per-entry timestamps.
module io_trace_capture #(
  parameter int unsigned           DATA_W  = 8,
  parameter int unsigned           ADDR_W  = 4,
  parameter int unsigned           DEPTH   = 16,
  parameter int unsigned           TS_W    = 16,
  parameter logic [2**ADDR_W-1:0]  CH_MASK = '1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        io_addr,
  input  logic [DATA_W-1:0]        io_data,
  input  logic                     io_we,
  input  logic                     capture_en,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q, rd_valid_q;
  logic [7:0]        drop_cnt_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;

  logic flush, qual, is_full, is_empty, pop, push, drop;

  // flush gates every accept signal so clear/reset discard same-cycle traffic
  always_comb begin
    flush    = reset | clear;
    is_full  = (count_q == CNT_W'(DEPTH));
    is_empty = (count_q == '0);
    qual     = io_we & capture_en & CH_MASK[io_addr];
    pop      = rd_en & ~is_empty & ~flush;
    push     = qual & (~is_full | pop) & ~flush;
    drop     = qual & is_full & ~pop & ~flush;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Read data is only cleared by reset; clear leaves the last popped entry visible.
  always_ff @(posedge clk) begin
    rd_valid_q <= pop;
    if (reset) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (pop) begin
      rd_addr_q <= mem_addr[rd_ptr_q];
      rd_data_q <= mem_data[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= io_addr;
      mem_data[wr_ptr_q] <= io_data;
    end
  end

`ifdef IO_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] rd_ts_q;
  logic [TS_W-1:0] mem_ts [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_ts[wr_ptr_q] <= ts_q;
  end

  always_ff @(posedge clk) begin
    if (reset)    rd_ts_q <= '0;
    else if (pop) rd_ts_q <= mem_ts[rd_ptr_q];
  end

  assign rd_ts = rd_ts_q;
`else
  assign rd_ts = '0;
`endif

  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_io_trace_capture.sv
// Bench for io_trace_capture: directed scenarios plus random traffic, each cycle compared
// against a queue-based reference model.
module tb_io_trace_capture;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 10;
  localparam logic [15:0] MASK  = 16'h7FF5;

  logic       clk = 1'b0;
  logic       reset, clear, io_we, capture_en, rd_en;
  logic [3:0] io_addr;
  logic [7:0] io_data;
  logic       rd_valid, empty, full, overflow;
  logic [3:0] rd_addr;
  logic [7:0] rd_data, drop_cnt;
  logic [TS_W-1:0] rd_ts;
  logic [4:0] count;

  always #5 clk = ~clk;

  io_trace_capture #(
    .DATA_W (8),
    .ADDR_W (4),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W),
    .CH_MASK(MASK)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .io_addr   (io_addr),
    .io_data   (io_data),
    .io_we     (io_we),
    .capture_en(capture_en),
    .clear     (clear),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ts     (rd_ts),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic [3:0]  a;
    logic [7:0]  d;
    int unsigned t;
  } ent_t;

  ent_t        q[$];
  int unsigned m_ts    = 0;
  bit          m_ov    = 1'b0;
  int unsigned m_drops = 0;
  bit          m_rv    = 1'b0;
  logic [3:0]  m_ra    = '0;
  logic [7:0]  m_rd    = '0;
  int unsigned m_rt    = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, from the pre-edge inputs and model state.
  task automatic model_edge(input bit rst, input bit clr, input bit we, input bit cen,
                            input bit rd, input logic [3:0] a, input logic [7:0] d);
    int unsigned cur_ts;
    bit          qual, was_full, popped;
    ent_t        e;
    cur_ts = m_ts;
    if (rst) begin
      q.delete();
      m_ts = 0; m_ov = 0; m_drops = 0; m_rv = 0;
      m_ra = '0; m_rd = '0; m_rt = 0;
      return;
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
    if (clr) begin
      q.delete();
      m_ov = 0; m_drops = 0; m_rv = 0;
      return;
    end
    was_full = (q.size() == DEPTH);
    popped   = rd && (q.size() != 0);
    qual     = we && cen && MASK[a];
    m_rv     = popped;
    if (popped) begin
      e    = q.pop_front();
      m_ra = e.a; m_rd = e.d; m_rt = e.t;
    end
    if (qual) begin
      if (!was_full || popped) begin
        e.a = a; e.d = d; e.t = cur_ts;
        q.push_back(e);
      end else begin
        m_ov = 1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic compare();
    int unsigned exp_ts;
`ifdef IO_TRACE_TIMESTAMP_EN
    exp_ts = m_rt;
`else
    exp_ts = 0;
`endif
    check("count",    32'(count),    32'(q.size()));
    check("empty",    32'(empty),    32'(q.size() == 0));
    check("full",     32'(full),     32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    check("rd_valid", 32'(rd_valid), 32'(m_rv));
    check("rd_addr",  32'(rd_addr),  32'(m_ra));
    check("rd_data",  32'(rd_data),  32'(m_rd));
    check("rd_ts",    32'(rd_ts),    exp_ts);
  endtask

  task automatic step(input bit rst, input bit clr, input bit we, input bit cen, input bit rd,
                      input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    reset = rst; clear = clr; io_we = we; capture_en = cen; rd_en = rd;
    io_addr = a; io_data = d;
    @(posedge clk);
    model_edge(rst, clr, we, cen, rd, a, d);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 4'h0, 8'h00);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    step(0, 0, 1, 1, 0, a, d);
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1, 4'h0, 8'h00);
  endtask

  initial begin
    reset = 1; clear = 0; io_we = 0; capture_en = 0; rd_en = 0; io_addr = '0; io_data = '0;
    step(1, 0, 0, 0, 0, 4'h0, 8'h00);
    step(1, 0, 0, 0, 0, 4'h0, 8'h00);

    // Three writes at ts 5/6/7, popped in order
    idle(5);
    wr(4'h0, 8'h01); wr(4'h0, 8'h02); wr(4'h0, 8'h03);
    pop(3);
    idle(2);

    // Channel mask: addr 1 and 3 are disabled
    wr(4'h0, 8'hA0); wr(4'h1, 8'hA1); wr(4'h2, 8'hA2); wr(4'h3, 8'hA3);
    step(0, 0, 1, 0, 0, 4'h2, 8'hA4);
    pop(4);

    // Overfill, then push+pop while full, then drain
    for (int i = 0; i < 20; i++) wr(4'h2, 8'(i + 16));
    step(0, 0, 1, 1, 1, 4'h4, 8'hEE);
    pop(18);

    // 10 held with overflow, clear together with a write, then pop on empty
    for (int i = 0; i < 20; i++) wr(4'h5, 8'(i));
    pop(6);
    step(0, 1, 1, 1, 1, 4'h5, 8'h77);
    pop(2);

    // drop_cnt saturation
    for (int i = 0; i < DEPTH + 260; i++) wr(4'h6, 8'(i));
    step(0, 1, 0, 1, 0, 4'h0, 8'h00);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      step(($urandom % 200) == 0, ($urandom % 50) == 0, ($urandom % 100) < 60,
           ($urandom % 10) != 0, ($urandom % 100) < 40, 4'($urandom), 8'($urandom));

    // Timestamp wrap
    step(1, 0, 0, 0, 0, 4'h0, 8'h00);
    idle((1 << TS_W) + 2);
    wr(4'h7, 8'h5A);
    pop(1);

    // Reset mid-stream with 5 entries
    for (int i = 0; i < 5; i++) wr(4'h8, 8'(i + 100));
    step(1, 0, 1, 1, 1, 4'h8, 8'hFF);
    idle(3);
    wr(4'h8, 8'h42);
    pop(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
